// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of an external 2**swidth:1 mux and captures one sample per channel.
// Latency: first capture DWELL edges after the start edge, then one capture every DWELL edges.
// Backpressure: none; the consumer must accept every dout_valid pulse, and stop aborts at once.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   start, stop        level-sampled scan request / abort (stop wins)
//   mode               0 = single pass, 1 = continuous (sampled at start)
//   ch_en              channel enable mask (sampled at start)
//   din                mux output; sel drives the mux select
//   dout, dout_ch      captured sample and its channel, qualified by dout_valid
//   busy, done         scanning flag and single-pass completion pulse
module mux_scan_ctrl #(
  parameter int width  = 4,
  parameter int swidth = 4,
  parameter int DWELL  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [2**swidth-1:0]   ch_en,
  input  logic [width-1:0]       din,
  output logic [swidth-1:0]      sel,
  output logic [width-1:0]       dout,
  output logic [swidth-1:0]      dout_ch,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int nch = 2**swidth;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [nch-1:0]    mask_r;
  logic              mode_r;
  logic [swidth-1:0] first_new;
  logic [swidth-1:0] first_lat;
  logic [swidth-1:0] next_ch;
  logic              has_next;

  function automatic logic [swidth-1:0] lowest(input logic [nch-1:0] m);
    logic [swidth-1:0] r;
    r = '0;
    // Descending walk so the lowest set bit is the last one written.
    for (int i = nch - 1; i >= 0; i--) begin
      if (m[i]) r = swidth'(i);
    end
    return r;
  endfunction

  assign first_new = lowest(ch_en);
  assign first_lat = lowest(mask_r);

  // Next enabled channel strictly above sel; falls back to the lowest
  // enabled channel, which is the wrap target in continuous mode.
  always_comb begin
    has_next = 1'b0;
    next_ch  = first_lat;
    for (int i = nch - 1; i >= 0; i--) begin
      if (mask_r[i] && (i > int'(sel))) begin
        has_next = 1'b1;
        next_ch  = swidth'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mask_r     <= '0;
      mode_r     <= 1'b0;
      sel        <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && (|ch_en)) begin
            mask_r <= ch_en;
            mode_r <= mode;
            sel    <= first_new;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (stop) begin
            // Abort wins over a coincident capture; dout/dout_ch hold.
            state <= IDLE;
            busy  <= 1'b0;
            sel   <= '0;
            cnt   <= '0;
          end else if (cnt == 8'(DWELL - 1)) begin
            cnt        <= '0;
            dout       <= din;
            dout_ch    <= sel;
            dout_valid <= 1'b1;
            if (has_next || mode_r) begin
              sel <= next_ch;
            end else begin
              // Last channel of a single pass: done pulses on the next edge
              // so it never overlaps dout_valid.
              sel   <= '0;
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  localparam int W  = 4;
  localparam int SW = 4;
  localparam int N  = 16;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [N-1:0]  ch_en = '0;
  logic [W-1:0]  din;
  logic [SW-1:0] sel;
  logic [W-1:0]  dout;
  logic [SW-1:0] dout_ch;
  logic          dout_valid;
  logic          busy;
  logic          done;

  logic [W-1:0]  data [N];
  logic [N-1:0]  lmask = '0;
  bit            mon_on = 1'b0;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  typedef struct {
    int          ch;
    logic [W-1:0] d;
    int          at;
  } exp_t;

  exp_t capq[$];
  int   doneq[$];

  mux_scan_ctrl #(.width(W), .swidth(SW), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .ch_en(ch_en), .din(din), .sel(sel), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  // Behavioural mux: din follows whatever channel sel points at.
  assign din = data[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a capture or done.
  always @(negedge clk) begin
    if (mon_on) begin
      if (dout_valid) begin
        if (capq.size() == 0) begin
          chk("unexpected_capture", 1, 0);
        end else begin
          exp_t e;
          e = capq.pop_front();
          chk("cap_ch", int'(dout_ch), e.ch);
          chk("cap_dat", int'(dout), int'(e.d));
          chk("cap_time", cyc, e.at);
        end
      end
      if (done) begin
        if (doneq.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_time", cyc, doneq.pop_front());
      end
      if (dout_valid && done) chk("valid_done_overlap", 1, 0);
      if (busy && !dout_valid) chk("sel_enabled", int'(lmask[sel]), 1);
    end
  end

  // Model: captures walk the enabled channels in ascending order, one every
  // DW edges after the start edge; single pass ends with done one edge later.
  task automatic run_scan(input logic [N-1:0] m, input logic md,
                          input int ncap, input bit stop_on_cap);
    int   en[$];
    int   s;
    int   t;
    exp_t e;
    logic [W-1:0] last_d;
    for (int i = 0; i < N; i++) if (m[i]) en.push_back(i);
    @(negedge clk);
    start = 1'b1; ch_en = m; mode = md; lmask = m;
    s = cyc + 1;
    t = 0;
    last_d = '0;
    if (!md) begin
      for (int k = 0; k < en.size(); k++) begin
        e.ch = en[k]; e.d = data[en[k]]; e.at = s + (k + 1) * DW;
        capq.push_back(e);
      end
      doneq.push_back(s + en.size() * DW + 1);
    end else begin
      t = stop_on_cap ? s + (ncap + 1) * DW : s + ncap * DW + 1;
      for (int k = 0; k < ncap; k++) begin
        e.ch = en[k % en.size()]; e.d = data[e.ch]; e.at = s + (k + 1) * DW;
        capq.push_back(e);
        last_d = e.d;
      end
    end
    @(negedge clk);
    start = 1'b0;
    ch_en = N'($urandom);      // mid-scan changes must be ignored
    mode  = 1'($urandom);
    if (!md) begin
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      chk("single_end_busy", int'(busy), 0);
    end else begin
      while (cyc < t - 1) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_sel", int'(sel), 0);
      chk("stop_dout_hold", int'(dout), int'(last_d));
    end
    repeat (3) @(negedge clk);
    chk("cap_queue_drained", capq.size(), 0);
    chk("done_queue_drained", doneq.size(), 0);
    capq.delete();
    doneq.delete();
  endtask

  initial begin
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) data[i] = W'($urandom);
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_ch", int'(dout_ch), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Start ignored when stop is also high, or when no channel is enabled.
    @(negedge clk);
    start = 1'b1; stop = 1'b1; ch_en = '1;
    repeat (3) @(negedge clk);
    chk("idle_start_stop_busy", int'(busy), 0);
    stop = 1'b0; ch_en = '0;
    repeat (3) @(negedge clk);
    chk("idle_no_en_busy", int'(busy), 0);
    chk("idle_no_en_sel", int'(sel), 0);
    start = 1'b0;

    // Full single pass with din = sel+1 mod 16.
    for (int i = 0; i < N; i++) data[i] = W'((i + 1) % 16);
    run_scan(16'hFFFF, 1'b0, 0, 1'b0);

    // Sparse mask single pass.
    for (int i = 0; i < N; i++) data[i] = W'($urandom);
    run_scan(16'h8421, 1'b0, 0, 1'b0);

    // Single channel continuous, then stop off a capture edge.
    run_scan(16'h0010, 1'b1, 5, 1'b0);

    // Stop on a capture edge.
    run_scan(16'h0C30, 1'b1, 3, 1'b1);

    // Randomized scans.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) data[i] = W'($urandom);
      m = N'($urandom);
      if (m == '0) m = 16'h0001;
      run_scan(m, 1'($urandom), int'($urandom_range(1, 8)), 1'($urandom));
    end

    // Asynchronous reset while channel 7 is selected.
    mon_on = 1'b0;
    @(negedge clk);
    start = 1'b1; ch_en = '1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && sel != 4'd7; i++) @(negedge clk);
    chk("reach_ch7", int'(sel), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", int'(sel), 0);
    chk("arst_dout", int'(dout), 0);
    chk("arst_dout_ch", int'(dout_ch), 0);
    chk("arst_valid", int'(dout_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_busy", int'(busy), 0);
    chk("post_rst_idle_sel", int'(sel), 0);
    mon_on = 1'b1;
    for (int i = 0; i < N; i++) data[i] = W'($urandom);
    run_scan(16'hFFFF, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
